// File: rtl/sm_dmem_responder.sv
// Data-memory responder: word RAM plus an IO page (GPIO, TX FIFO, cycle counter).
// Define SM_DMEM_TIMER_EN to build the TCMP compare timer and the sticky timerHit flag.
module sm_dmem_responder #(
    parameter int unsigned RAM_AW     = 6,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GPIO_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       dmAddr,
    input  logic              dmWe,
    input  logic [31:0]       dmWData,
    output logic [31:0]       dmRData,
    output logic [GPIO_W-1:0] gpioOut,
    output logic [7:0]        txData,
    output logic              txValid,
    input  logic              txReady,
    output logic              timerHit
);
    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = PW + 1;
    localparam int unsigned RAM_WORDS = 2 ** RAM_AW;

    localparam logic [2:0] REG_GPIO    = 3'd0;
    localparam logic [2:0] REG_TXDATA  = 3'd1;
    localparam logic [2:0] REG_STATUS  = 3'd2;
    localparam logic [2:0] REG_COUNTER = 3'd3;
    localparam logic [2:0] REG_TCMP    = 3'd4;

    logic [31:0]       ram [RAM_WORDS];
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              overflow;
    logic [31:0]       counter;
    logic [GPIO_W-1:0] gpio;
    logic              timer_hit;

    logic              ram_sel;
    logic              io_sel;
    logic [2:0]        io_reg;
    logic [RAM_AW-1:0] ram_idx;
    logic              empty;
    logic              full;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              status_we;
    logic              counter_we;
    logic              unused_addr;

    assign ram_sel     = (dmAddr[31:28] == 4'h0);
    assign io_sel      = (dmAddr[31:28] == 4'hF);
    assign io_reg      = dmAddr[4:2];
    assign ram_idx     = dmAddr[RAM_AW+1:2];
    assign unused_addr = &{1'b0, dmAddr[27:RAM_AW+2], dmAddr[1:0]};

    assign empty      = (count == CW'(0));
    assign full       = (count == CW'(FIFO_DEPTH));
    assign push_req   = dmWe && io_sel && (io_reg == REG_TXDATA);
    assign push       = push_req && !full;
    assign pop        = txValid && txReady;
    assign status_we  = dmWe && io_sel && (io_reg == REG_STATUS);
    assign counter_we = dmWe && io_sel && (io_reg == REG_COUNTER);

    assign gpioOut  = gpio;
    assign txValid  = !empty;
    assign txData   = fifo_mem[rd_ptr];
    assign timerHit = timer_hit;

    // RAM and FIFO storage are deliberately unreset; only pointers/count reset.
    always_ff @(posedge clk) begin
        if (dmWe && ram_sel) ram[ram_idx] <= dmWData;
        if (push) fifo_mem[wr_ptr] <= dmWData[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            gpio     <= '0;
            counter  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            // A drop in the same cycle as a STATUS write keeps the flag set.
            if (push_req && full) overflow <= 1'b1;
            else if (status_we) overflow <= 1'b0;
            if (dmWe && io_sel && (io_reg == REG_GPIO)) gpio <= dmWData[GPIO_W-1:0];
            if (counter_we) counter <= dmWData;
            else counter <= counter + 32'd1;
        end
    end

`ifdef SM_DMEM_TIMER_EN
    logic [31:0] tcmp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcmp      <= 32'hFFFF_FFFF;
            timer_hit <= 1'b0;
        end else begin
            if (dmWe && io_sel && (io_reg == REG_TCMP)) tcmp <= dmWData;
            if (counter == tcmp) timer_hit <= 1'b1;
            else if (status_we) timer_hit <= 1'b0;
        end
    end
`else
    logic [31:0] tcmp;

    assign tcmp      = 32'h0;
    assign timer_hit = 1'b0;
`endif

    // Combinational read mux so single-cycle loads complete in the same cycle.
    always_comb begin
        dmRData = 32'h0;
        if (ram_sel) begin
            dmRData = ram[ram_idx];
        end else if (io_sel) begin
            case (io_reg)
                REG_GPIO:    dmRData = 32'(gpio);
                REG_STATUS:  dmRData = {16'h0, 8'(count), 4'h0, timer_hit, overflow, full, empty};
                REG_COUNTER: dmRData = counter;
                REG_TCMP:    dmRData = tcmp;
                default:     dmRData = 32'h0;
            endcase
        end
    end
endmodule
